// File: rtl/seg7_scroll_reader.sv
// seg7_scroll_reader
// Reads the 16-entry 7-segment character ROM one address at a time. Each
// fetched pattern is shifted into a 4-digit display buffer. The buffer is
// time-multiplexed onto a common 4-digit display with active-low segments
// and active-low digit selects.
//
// Digit 0 is the rightmost position and holds the newest character, so
// text enters from the right and scrolls left.
//
// An advance comes from one of two sources. With run=1 it is the scroll
// tick. With run=0 it is a rising edge on the debounced step switch. The
// run level selects exactly one source, so a scroll tick and a step edge
// in the same cycle still produce at most one advance.
module seg7_scroll_reader #(
  parameter int SCROLL_W = 22,  // scroll tick every 2^SCROLL_W clocks
  parameter int MUX_W    = 14   // digit-mux tick every 2^MUX_W clocks
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic       clr,
  input  logic [7:0] rom_dat,
  output logic [3:0] rom_adr,
  output logic [7:0] seg,
  output logic [3:0] dig,
  output logic       wrap
);

  // All segments off (active-low), shown on digits that hold no character yet.
  localparam logic [7:0] BLANK = 8'hFF;

  logic [SCROLL_W-1:0] r_scroll_cnt;
  logic [MUX_W-1:0]    r_mux_cnt;
  logic                r_step_prev;
  logic [3:0]          r_adr;
  logic [7:0]          r_dbuf [4];
  logic                r_wrap;
  logic [1:0]          r_idx;
  logic [7:0]          r_seg;
  logic [3:0]          r_dig;

  logic                w_stick;
  logic                w_mtick;
  logic                w_sedge;
  logic                w_adv;
  logic [3:0]          w_dig_sel;

  // Free-running scroll timebase. Only reset clears it; clr does not.
  // NOTE: sequential state uses non-blocking (<=) assignments, so every
  // register samples its pre-edge inputs and the ordering of always blocks
  // cannot change behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_scroll_cnt <= '0;
    else     r_scroll_cnt <= r_scroll_cnt + 1'b1;
  end

  // Free-running digit-mux timebase. It is independent of the scroll counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mux_cnt <= '0;
    else     r_mux_cnt <= r_mux_cnt + 1'b1;
  end

  assign w_stick = &r_scroll_cnt;
  assign w_mtick = &r_mux_cnt;

  // Remember the previous step level so a held switch advances only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_step_prev <= 1'b0;
    else     r_step_prev <= step;
  end

  assign w_sedge = step & ~r_step_prev;

  // The run level selects the advance source. A tick and an edge in the same
  // cycle therefore cannot produce two advances.
  assign w_adv = run ? w_stick : w_sedge;

  // Message position, shift buffer and wrap pulse. clr has priority over an
  // advance in the same cycle, so no partial shift survives a clear.
  // NOTE: the display buffer is reset (not left to power-up contents) so the
  // display shows blanks rather than garbage until the first advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_adr  <= 4'h0;
      r_wrap <= 1'b0;
      for (int i = 0; i < 4; i++) r_dbuf[i] <= BLANK;
    end else if (clr) begin
      r_adr  <= 4'h0;
      r_wrap <= 1'b0;
      for (int i = 0; i < 4; i++) r_dbuf[i] <= BLANK;
    end else if (w_adv) begin
      r_dbuf[3] <= r_dbuf[2];
      r_dbuf[2] <= r_dbuf[1];
      r_dbuf[1] <= r_dbuf[0];
      r_dbuf[0] <= rom_dat;
      r_adr     <= r_adr + 4'h1;
      r_wrap    <= (r_adr == 4'hF);
    end else begin
      r_wrap    <= 1'b0;
    end
  end

  // Digit index steps on each mux tick and wraps from 3 to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_idx <= 2'd0;
    else if (w_mtick) r_idx <= r_idx + 2'd1;
  end

  // Active-low one-hot-zero select for the current digit index.
  // NOTE: every combinational output gets a default before it is modified,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_dig_sel        = 4'b1111;
    w_dig_sel[r_idx] = 1'b0;
  end

  // Register the display drive every clock. It lags idx and the buffer by
  // one clock, which keeps the pins glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= BLANK;
      r_dig <= 4'b1110;
    end else begin
      r_seg <= r_dbuf[r_idx];
      r_dig <= w_dig_sel;
    end
  end

  assign rom_adr = r_adr;
  assign seg     = r_seg;
  assign dig     = r_dig;
  assign wrap    = r_wrap;

endmodule
